csa_reduce_pipe: RTL and testbench
==================================

Name: csa_reduce_pipe

Overview:
- Parametrised, pipelined multi-operand carry-save reduction tree.
- Reduces NUM_IN operands of WIDTH bits to a redundant sum/carry pair using layered 3:2 compressors, with one register stage per tree level.
- Optionally resolves the pair to a single binary result per transaction.
- Sits in front of the FP/integer multiply-accumulate datapath; replaces single-level 3:2 adder instances where more than three operands must be merged.

Parameters:
- WIDTH, 28, operand and result bit width; all arithmetic is modulo 2^WIDTH.
- NUM_IN, 8, operand count, legal range 3..16.
- TAG_W, 4, width of the opaque tag carried alongside each transaction.
- LEVELS, derived and not overridable: apply n -> 2*floor(n/3) + (n mod 3) starting from NUM_IN until n == 2. Examples: NUM_IN=3 gives 1, NUM_IN=4 gives 2, NUM_IN=8 gives 4.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts this cycle.
- in_ops  in  NUM_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- in_resolve  in  1  when 1, this transaction's result is resolved to binary.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_sum  out  WIDTH  sum vector, or the full binary result when resolved.
- out_carry  out  WIDTH  carry vector, already left-shifted; 0 when resolved.
- out_resolved  out  1  echoes in_resolve of the transaction.
- out_tag  out  TAG_W  echoes in_tag of the transaction.
- occupancy  out  $clog2(LEVELS+1)  number of valid pipeline stages.

Behaviour:
- Compressor cell, per bit i: s = a^b^c; maj = ab|ac|bc.
  - Carry vector is maj shifted left by 1; bit 0 is 0; maj[WIDTH-1] is discarded.
  - Leftover operands at a level (n mod 3 of them) pass to the next level unchanged.
- Invariant at every stage: the sum of all live vectors equals the sum of in_ops, mod 2^WIDTH.
- Pipeline structure:
  - Stage j (1..LEVELS) registers the outputs of tree level j plus the valid, resolve and tag bits.
  - The output ports are driven directly from stage LEVELS.
- Resolution:
  - When out_resolved=1: out_sum = (sum + carry) mod 2^WIDTH and out_carry = 0.
  - The adder is combinational on the stage-LEVELS registers.
  - When out_resolved=0: the raw sum and carry are presented.
- Handshake:
  - Stage j advances when it is empty, or when its successor advances. For the last stage, the successor advancing means out_ready.
  - in_ready = stage-1 advance condition. Bubbles collapse.
  - Transfer occurs only when valid and ready are both 1.
  - While out_valid=1 and out_ready=0, out_* must hold stable.
- Latency and throughput:
  - Latency is LEVELS cycles from the accepting edge to out_valid when out_ready is held 1.
  - Throughput is 1 transaction per cycle.
  - Order is preserved.
- occupancy equals the count of set stage valid bits. It is LEVELS when full. When the pipe is full and out_ready=0, in_ready=0.
- Simultaneous accept and drain on a full pipe: both happen on the same edge and occupancy is unchanged.
- Reset:
  - All valid bits clear and data/tag/resolve registers are set to 0.
  - out_valid=0, out_sum=0, out_carry=0, out_resolved=0, out_tag=0, occupancy=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight transactions with no output.
  - in_ready=1 on the first cycle after deassertion.
- Overflow wraps silently. No status or error signalling.

Test Plan:
- WIDTH=28, NUM_IN=8, out_ready=1; operands 1..8 with in_resolve=1 -> after 4 cycles out_valid=1, out_sum=36, out_carry=0, tag echoed.
- All eight operands 0xFFFFFFF with resolve=0 -> (out_sum + out_carry) mod 2^28 = 0xFFFFFF8; resolve=1 -> out_sum=0xFFFFFF8.
- Back-to-back stream of 20 random transactions, alternating resolve, out_ready=1 -> 20 outputs in order, one per cycle after 4-cycle fill, each matching the model.
- Fill pipe, hold out_ready=0 for 6 cycles -> occupancy=4, in_ready=0, outputs stable; release -> drain in order with no loss or duplication.
- Random out_ready with 30% stall probability and random in_valid -> scoreboard matches, no drop, out_* stable under stall.
- Assert reset with 3 transactions in flight -> all outputs 0 immediately, no stale output after release; NUM_IN=3 build gives 1-cycle latency with operands 5,6,7 resolving to 18.

Source files
------------

// File: rtl/csa_reduce_pipe.sv
// csa_reduce_pipe: pipelined carry-save reduction of NUM_IN operands down to a
// sum/carry pair using layered 3:2 compressors, one register stage per tree
// level. The last stage can optionally resolve the pair to a binary result.
// Legal NUM_IN range is 3..16; LEVELS follows n -> 2*floor(n/3) + n%3 until n == 2.
module csa_reduce_pipe #(
  parameter int WIDTH  = 28,
  parameter int NUM_IN = 8,
  parameter int TAG_W  = 4,
  localparam int LEVELS = (NUM_IN <= 3)  ? 1 :
                          (NUM_IN <= 4)  ? 2 :
                          (NUM_IN <= 6)  ? 3 :
                          (NUM_IN <= 9)  ? 4 :
                          (NUM_IN <= 13) ? 5 : 6,
  localparam int OCC_W  = $clog2(LEVELS + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_ops,
  input  logic                      in_resolve,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum,
  output logic [WIDTH-1:0]          out_carry,
  output logic                      out_resolved,
  output logic [TAG_W-1:0]          out_tag,
  output logic [OCC_W-1:0]          occupancy
);

  // Number of live vectors entering tree level lvl+1 (lvl = 0 is the raw operands).
  function automatic int vec_count(input int lvl);
    int n;
    n = NUM_IN;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  genvar j;
  generate
    for (j = 1; j <= LEVELS; j++) begin : g_lvl
      localparam int N_IN  = vec_count(j - 1);
      localparam int NG    = N_IN / 3;
      localparam int NR    = N_IN % 3;
      localparam int N_OUT = 2 * NG + NR;

      logic [N_IN-1:0][WIDTH-1:0]  src;
      logic [N_OUT-1:0][WIDTH-1:0] d;
      logic [N_OUT-1:0][WIDTH-1:0] q;
      logic                        vld_q;
      logic                        res_q;
      logic [TAG_W-1:0]            tag_q;
      logic                        prev_vld;
      logic                        prev_res;
      logic [TAG_W-1:0]            prev_tag;
      logic                        adv;
      logic                        next_adv;
      logic [OCC_W-1:0]            cnt;

      if (j == 1) begin : g_src
        assign src      = in_ops;
        assign prev_vld = in_valid;
        assign prev_res = in_resolve;
        assign prev_tag = in_tag;
        assign cnt      = OCC_W'(vld_q);
      end else begin : g_src
        assign src      = g_lvl[j-1].q;
        assign prev_vld = g_lvl[j-1].vld_q;
        assign prev_res = g_lvl[j-1].res_q;
        assign prev_tag = g_lvl[j-1].tag_q;
        assign cnt      = g_lvl[j-1].cnt + OCC_W'(vld_q);
      end

      // The last stage is released by the consumer; earlier ones by their successor.
      if (j == LEVELS) begin : g_nxt
        assign next_adv = out_ready;
      end else begin : g_nxt
        assign next_adv = g_lvl[j+1].adv;
      end

      assign adv = !vld_q || next_adv;

      // Each group of three vectors compresses to a sum and a shifted carry;
      // the majority MSB falls off the top because arithmetic is mod 2^WIDTH.
      genvar g;
      for (g = 0; g < NG; g++) begin : g_csa
        logic [WIDTH-1:0] a, b, c, maj;
        assign a            = src[3*g];
        assign b            = src[3*g+1];
        assign c            = src[3*g+2];
        assign maj          = (a & b) | (a & c) | (b & c);
        assign d[2*g]       = a ^ b ^ c;
        assign d[2*g+1]     = maj << 1;
      end

      genvar r;
      for (r = 0; r < NR; r++) begin : g_pass
        assign d[2*NG+r] = src[3*NG+r];
      end

      // Stage register: loads the level result whenever the stage may advance,
      // which also lets bubbles collapse.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          res_q <= 1'b0;
          tag_q <= '0;
          q     <= '0;
        end else if (adv) begin
          vld_q <= prev_vld;
          res_q <= prev_res;
          tag_q <= prev_tag;
          q     <= d;
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] fin_s;
  logic [WIDTH-1:0] fin_c;

  assign fin_s        = g_lvl[LEVELS].q[0];
  assign fin_c        = g_lvl[LEVELS].q[1];
  assign in_ready     = g_lvl[1].adv;
  assign out_valid    = g_lvl[LEVELS].vld_q;
  assign out_resolved = g_lvl[LEVELS].res_q;
  assign out_tag      = g_lvl[LEVELS].tag_q;
  assign occupancy    = g_lvl[LEVELS].cnt;

  // Present the raw pair, or collapse it with a carry-propagate add when resolving.
  always_comb begin
    out_sum   = fin_s;
    out_carry = fin_c;
    if (g_lvl[LEVELS].res_q) begin
      out_sum   = fin_s + fin_c;
      out_carry = '0;
    end
  end

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Scoreboard bench for csa_reduce_pipe: an 8-operand build plus a 3-operand build.
module tb_csa_reduce_pipe;
  localparam int W   = 28;
  localparam int N   = 8;
  localparam int T   = 4;
  localparam int LV  = 4;
  localparam int LV3 = 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_ops = '0;
  logic           in_resolve = 1'b0;
  logic [T-1:0]   in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_sum, out_carry;
  logic           out_resolved;
  logic [T-1:0]   out_tag;
  logic [2:0]     occupancy;

  logic           in_valid3 = 1'b0;
  logic           in_ready3;
  logic [3*W-1:0] in_ops3 = '0;
  logic           in_resolve3 = 1'b0;
  logic [T-1:0]   in_tag3 = '0;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;
  logic [W-1:0]   out_sum3, out_carry3;
  logic           out_resolved3;
  logic [T-1:0]   out_tag3;
  logic [0:0]     occupancy3;

  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(N), .TAG_W(T)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .in_resolve(in_resolve), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_resolved(out_resolved), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(3), .TAG_W(T)) dut3 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_ops(in_ops3),
    .in_resolve(in_resolve3), .in_tag(in_tag3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3),
    .out_carry(out_carry3), .out_resolved(out_resolved3), .out_tag(out_tag3),
    .occupancy(occupancy3)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         res;
    logic [T-1:0] tag;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq3[$];
  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model_sum(input logic [N*W-1:0] ops);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + ops[k*W +: W];
    return s;
  endfunction

  task automatic check_out(input exp_t e, input logic [W-1:0] s, input logic [W-1:0] c,
                           input logic r, input logic [T-1:0] tg, input int lat, input string p);
    logic [W-1:0] tot;
    tot = s + c;
    if (e.res) begin
      chk({p, "_res_sum"}, s, e.sum);
      chk({p, "_res_carry"}, c, '0);
    end else begin
      chk({p, "_raw_total"}, tot, e.sum);
      chk({p, "_raw_carry_lsb"}, W'(c[0]), '0);
    end
    chk({p, "_resolved"}, W'(r), W'(e.res));
    chk({p, "_tag"}, W'(tg), W'(e.tag));
    if (e.lat) chk({p, "_latency"}, W'(cyc - e.cyc), W'(lat));
  endtask

  // Consumer readiness: always, never, or random with 30% stall.
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 99) >= 30);
    endcase
  end

  // Monitor: pop and compare on every transfer, and check stability under stall.
  logic         hold_p = 1'b0;
  logic [W-1:0] hs, hc;
  logic         hr;
  logic [T-1:0] ht;
  exp_t         me;
  always @(negedge clock) begin
    if (reset) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        chk("hold_valid", W'(out_valid), W'(1));
        chk("hold_sum", out_sum, hs);
        chk("hold_carry", out_carry, hc);
        chk("hold_resolved", W'(out_resolved), W'(hr));
        chk("hold_tag", W'(out_tag), W'(ht));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out actual=valid sum=%0h required=no_output", out_sum);
        end else begin
          me = sbq.pop_front();
          check_out(me, out_sum, out_carry, out_resolved, out_tag, LV, "n8");
        end
      end
      hold_p = out_valid && !out_ready;
      hs = out_sum; hc = out_carry; hr = out_resolved; ht = out_tag;
      if (out_valid3 && out_ready3) begin
        if (sbq3.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out3 actual=valid sum=%0h required=no_output", out_sum3);
        end else begin
          me = sbq3.pop_front();
          check_out(me, out_sum3, out_carry3, out_resolved3, out_tag3, LV3, "n3");
        end
      end
    end
  end

  task automatic send(input logic [N*W-1:0] ops, input logic res, input logic [T-1:0] tag, input bit lat);
    exp_t e;
    bit done;
    done = 0;
    in_ops = ops; in_resolve = res; in_tag = tag; in_valid = 1'b1;
    e.sum = model_sum(ops); e.res = res; e.tag = tag; e.lat = lat; e.cyc = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        e.cyc = cyc;
        sbq.push_back(e);
        done = 1;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0h", tag);
    end
  endtask

  task automatic send3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic res, input logic [T-1:0] tag, input logic [W-1:0] exp_sum);
    exp_t e;
    bit done;
    done = 0;
    in_ops3 = {c, b, a}; in_resolve3 = res; in_tag3 = tag; in_valid3 = 1'b1;
    e.sum = exp_sum; e.res = res; e.tag = tag; e.lat = 1; e.cyc = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (in_ready3) begin
        e.cyc = cyc;
        sbq3.push_back(e);
        done = 1;
      end
      @(posedge clock); #1;
    end
    in_valid3 = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send3_timeout actual=not_accepted required=accepted tag=%0h", tag);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      if (sbq.size() == 0 && sbq3.size() == 0) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d,%0d_pending required=0", sbq.size(), sbq3.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  logic [N*W-1:0] ops_v;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_carry", out_carry, '0);
    chk("rst_out_resolved", W'(out_resolved), '0);
    chk("rst_out_tag", W'(out_tag), '0);
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    // Operands 1..8, resolved: 36
    for (int k = 0; k < N; k++) ops_v[k*W +: W] = W'(k + 1);
    send(ops_v, 1'b1, 4'hA, 1'b1);
    wait_drain();

    // All-ones operands: sum is -8 mod 2^28
    for (int k = 0; k < N; k++) ops_v[k*W +: W] = 28'hFFFFFFF;
    send(ops_v, 1'b0, 4'h3, 1'b1);
    send(ops_v, 1'b1, 4'h4, 1'b1);
    wait_drain();

    // Back-to-back stream, full pipe accepts and drains on the same edge
    for (int i = 0; i < 20; i++) begin
      if (i >= LV) begin
        chk("stream_occupancy", W'(occupancy), W'(LV));
        chk("stream_in_ready", W'(in_ready), W'(1));
      end
      for (int k = 0; k < N; k++) ops_v[k*W +: W] = W'($urandom);
      send(ops_v, i[0], T'(i), 1'b1);
    end
    wait_drain();

    // Fill with consumer stalled, hold 6 cycles, then release
    rdy_mode = 1;
    @(posedge clock); #2;
    for (int i = 0; i < LV; i++) begin
      for (int k = 0; k < N; k++) ops_v[k*W +: W] = W'($urandom);
      send(ops_v, ~i[0], T'(i + 8), 1'b0);
    end
    repeat (6) @(negedge clock);
    chk("full_occupancy", W'(occupancy), W'(LV));
    chk("full_in_ready", W'(in_ready), '0);
    chk("full_out_valid", W'(out_valid), W'(1));
    @(posedge clock); #2;
    rdy_mode = 0;
    wait_drain();

    // Random stalls and random input gaps
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < N; k++) ops_v[k*W +: W] = W'($urandom);
      send(ops_v, 1'($urandom_range(0, 1)), T'($urandom_range(0, 15)), 1'b0);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    wait_drain();
    idle(2);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) ops_v[k*W +: W] = W'(i * 100 + k);
      send(ops_v, 1'b1, T'(i + 1), 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_out_sum", out_sum, '0);
    chk("midrst_out_carry", out_carry, '0);
    chk("midrst_out_tag", W'(out_tag), '0);
    chk("midrst_occupancy", W'(occupancy), '0);
    chk("midrst_in_ready", W'(in_ready), W'(1));
    sbq.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_post_in_ready", W'(in_ready), W'(1));
    idle(8);
    chk("midrst_no_stale", W'(out_valid), '0);

    // Three-operand build: single-level latency
    send3(28'd5, 28'd6, 28'd7, 1'b1, 4'h5, 28'd18);
    send3(28'd1, 28'd2, 28'd4, 1'b0, 4'h6, 28'd7);
    send3(28'hFFFFFFF, 28'd1, 28'd0, 1'b1, 4'h7, 28'd0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
